// File: rtl/d_ff_en_checker.sv
`timescale 1ns/1ps
// Checks an enable-load D register against a reference model built from the register's own stimulus.
// The model has 1-cycle latency. Results are registered one edge after each compare edge. No backpressure.
module d_ff_en_checker #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ARM_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic             stop_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             en_in,
  input  logic             dut_rst_in,
  input  logic [WIDTH-1:0] dut_q_in,
  output logic [WIDTH-1:0] exp_q_out,
  output logic             mismatch_out,
  output logic [CNT_W-1:0] err_cnt_out,
  output logic [CNT_W-1:0] cycle_cnt_out,
  output logic [CNT_W-1:0] first_err_out,
  output logic             first_err_vld_out,
  output logic [1:0]       state_out,
  output logic             pass_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARM   = 2'b01,
    ST_CHECK = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // The arm counter is loaded with ARM_CYCLES-1, so $clog2(ARM_CYCLES) bits are enough.
  localparam int unsigned      ARM_W    = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LOAD = (ARM_CYCLES > 0) ? ARM_W'(ARM_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [ARM_W-1:0]   arm_q, arm_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               mis_q, mis_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [CNT_W-1:0]   ferr_q, ferr_d;
  logic               fvld_q, fvld_d;
  logic               pass_q, pass_d;
  logic               start_run;
  logic               compare;

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    exp_d     = exp_q;
    mis_d     = 1'b0;
    err_d     = err_q;
    cyc_d     = cyc_q;
    ferr_d    = ferr_q;
    fvld_d    = fvld_q;
    pass_d    = 1'b0;
    start_run = 1'b0;
    compare   = 1'b0;

    if (dut_rst_in) begin
      exp_d = '0;
    end else if (en_in) begin
      exp_d = d_in;
    end

    case (state_q)
      ST_IDLE: begin
        start_run = start_in;
      end
      ST_ARM: begin
        if (stop_in) begin
          state_d = ST_DONE;
        end else if (arm_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          arm_d = arm_q - ARM_W'(1);
        end
      end
      ST_CHECK: begin
        compare = 1'b1;
        if (stop_in) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        start_run = start_in;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (start_run) begin
      err_d  = '0;
      cyc_d  = '0;
      ferr_d = '0;
      fvld_d = 1'b0;
      if (ARM_CYCLES == 0) begin
        state_d = ST_CHECK;
      end else begin
        state_d = ST_ARM;
        arm_d   = ARM_LOAD;
      end
    end

    // Compare uses pre-edge values of both the model and the observed output.
    if (compare) begin
      if (cyc_q != CNT_MAX) begin
        cyc_d = cyc_q + CNT_ONE;
      end
      if (dut_q_in != exp_q) begin
        mis_d = 1'b1;
        if (err_q != CNT_MAX) begin
          err_d = err_q + CNT_ONE;
        end
        if (!fvld_q) begin
          ferr_d = cyc_q;
          fvld_d = 1'b1;
        end
      end
    end

    // The verdict includes the final compare edge and is frozen while in DONE.
    if (state_d == ST_DONE) begin
      pass_d = (state_q == ST_DONE) ? pass_q : (err_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      arm_q   <= '0;
      exp_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= '0;
      cyc_q   <= '0;
      ferr_q  <= '0;
      fvld_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      exp_q   <= exp_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      ferr_q  <= ferr_d;
      fvld_q  <= fvld_d;
      pass_q  <= pass_d;
    end
  end

  assign exp_q_out         = exp_q;
  assign mismatch_out      = mis_q;
  assign err_cnt_out       = err_q;
  assign cycle_cnt_out     = cyc_q;
  assign first_err_out     = ferr_q;
  assign first_err_vld_out = fvld_q;
  assign state_out         = state_q;
  assign pass_out          = pass_q;

endmodule

// File: tb/tb_d_ff_en_checker.sv
`timescale 1ns/1ps
// Directed bench: an ideal enable-load register feeds checker A (16-bit counters, 2 arm cycles);
// checker B (4-bit counters, no arm phase) watches a stuck output.
module tb_d_ff_en_checker;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  // Data toggles every 7ns on a half-ns phase so it never lands on a clock edge.
  logic d_tog = 1'b0;
  initial begin
    #3.5;
    forever #7 d_tog = ~d_tog;
  end

  logic       reset_in, d_sel, d_fix, en, dut_rst, inj;
  logic       start_a, stop_a, start_b, stop_b, q_b;
  logic       d_in, ideal_q, q_a;

  assign d_in = d_sel ? d_tog : d_fix;
  assign q_a  = ideal_q ^ inj;

  always @(posedge clk) begin
    if (dut_rst)  ideal_q <= 1'b0;
    else if (en)  ideal_q <= d_in;
  end

  logic        exp_a, mis_a, fvld_a, pass_a;
  logic [15:0] err_a, cyc_a, ferr_a;
  logic [1:0]  st_a;
  logic        exp_b, mis_b, fvld_b, pass_b;
  logic [3:0]  err_b, cyc_b, ferr_b;
  logic [1:0]  st_b;

  d_ff_en_checker #(.WIDTH(1), .CNT_W(16), .ARM_CYCLES(2)) u_a (
    .clk(clk), .reset_in(reset_in), .start_in(start_a), .stop_in(stop_a),
    .d_in(d_in), .en_in(en), .dut_rst_in(dut_rst), .dut_q_in(q_a),
    .exp_q_out(exp_a), .mismatch_out(mis_a), .err_cnt_out(err_a),
    .cycle_cnt_out(cyc_a), .first_err_out(ferr_a), .first_err_vld_out(fvld_a),
    .state_out(st_a), .pass_out(pass_a)
  );

  d_ff_en_checker #(.WIDTH(1), .CNT_W(4), .ARM_CYCLES(0)) u_b (
    .clk(clk), .reset_in(reset_in), .start_in(start_b), .stop_in(stop_b),
    .d_in(d_in), .en_in(en), .dut_rst_in(dut_rst), .dut_q_in(q_b),
    .exp_q_out(exp_b), .mismatch_out(mis_b), .err_cnt_out(err_b),
    .cycle_cnt_out(cyc_b), .first_err_out(ferr_b), .first_err_vld_out(fvld_b),
    .state_out(st_b), .pass_out(pass_b)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_in = 1'b1; d_sel = 1'b0; d_fix = 1'b0; en = 1'b0; dut_rst = 1'b1; inj = 1'b0;
    start_a = 1'b0; stop_a = 1'b0; start_b = 1'b0; stop_b = 1'b0; q_b = 1'b0;

    // 1: reset
    tick(); tick();
    reset_in = 1'b0; dut_rst = 1'b0;
    chk("t1_state",  st_a,   2'b00);
    chk("t1_exp",    exp_a,  1'b0);
    chk("t1_mis",    mis_a,  1'b0);
    chk("t1_err",    err_a,  16'd0);
    chk("t1_cyc",    cyc_a,  16'd0);
    chk("t1_ferr",   ferr_a, 16'd0);
    chk("t1_vld",    fvld_a, 1'b0);
    chk("t1_pass",   pass_a, 1'b0);
    chk("t1_state_b", st_b,  2'b00);
    chk("t1_err_b",  err_b,  4'd0);

    // 2: ideal DUT, 100 compare edges, en=1 then 0
    d_sel = 1'b1; en = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t2_arm", st_a, 2'b01);
    tick();
    chk("t2_arm2", st_a, 2'b01);
    tick();
    chk("t2_check", st_a, 2'b10);
    chk("t2_cyc0",  cyc_a, 16'd0);
    for (int i = 0; i < 99; i++) begin
      if (i == 50) en = 1'b0;
      tick();
      chk("t2_mis", mis_a, 1'b0);
    end
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    chk("t2_state", st_a,   2'b11);
    chk("t2_err",   err_a,  16'd0);
    chk("t2_cyc",   cyc_a,  16'd100);
    chk("t2_pass",  pass_a, 1'b1);
    chk("t2_vld",   fvld_a, 1'b0);
    tick();
    chk("t2_pass_hold", pass_a, 1'b1);

    // 3: invert observed output on compare cycles 5,6,7
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t3_arm",  st_a,   2'b01);
    chk("t3_clr",  cyc_a,  16'd0);
    chk("t3_pass", pass_a, 1'b0);
    tick(); tick();
    for (int k = 0; k < 12; k++) begin
      inj = (k >= 5 && k <= 7);
      tick();
      chk("t3_mis", mis_a, (k >= 5 && k <= 7) ? 32'd1 : 32'd0);
    end
    inj = 1'b0;
    chk("t3_err",  err_a,  16'd3);
    chk("t3_ferr", ferr_a, 16'd5);
    chk("t3_vld",  fvld_a, 1'b1);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    chk("t3_state", st_a,   2'b11);
    chk("t3_cyc",   cyc_a,  16'd13);
    chk("t3_pass",  pass_a, 1'b0);

    // 5: reference model reset / enable behaviour
    d_sel = 1'b0; d_fix = 1'b1; en = 1'b1; dut_rst = 1'b1;
    tick();
    chk("t5_rst", exp_a, 1'b0);
    dut_rst = 1'b0; en = 1'b0;
    tick();
    chk("t5_hold0", exp_a, 1'b0);
    en = 1'b1;
    chk("t5_pre", exp_a, 1'b0);
    tick();
    chk("t5_load1", exp_a, 1'b1);
    d_fix = 1'b0; en = 1'b0;
    tick();
    chk("t5_hold1", exp_a, 1'b1);
    en = 1'b1;
    tick();
    chk("t5_load0", exp_a, 1'b0);

    // 4: 4-bit counters saturate with output stuck opposite the model
    start_b = 1'b1; tick(); start_b = 1'b0;
    chk("t4_check", st_b, 2'b10);
    q_b = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("t4_err",  err_b,  4'd15);
    chk("t4_cyc",  cyc_b,  4'd15);
    chk("t4_ferr", ferr_b, 4'd0);
    chk("t4_vld",  fvld_b, 1'b1);
    chk("t4_mis",  mis_b,  1'b1);
    stop_b = 1'b1; tick(); stop_b = 1'b0;
    chk("t4_state", st_b,  2'b11);
    chk("t4_pass",  pass_b, 1'b0);
    q_b = 1'b0;

    // 6: checker reset mid-run, then re-arm
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    chk("t6_check", st_a, 2'b10);
    inj = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    inj = 1'b0;
    chk("t6_err4", err_a, 16'd4);
    reset_in = 1'b1; tick(); reset_in = 1'b0;
    chk("t6_state", st_a,   2'b00);
    chk("t6_err",   err_a,  16'd0);
    chk("t6_vld",   fvld_a, 1'b0);
    chk("t6_cyc",   cyc_a,  16'd0);
    chk("t6_mis",   mis_a,  1'b0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    chk("t6_arm1", st_a, 2'b01);
    tick();
    chk("t6_arm2", st_a, 2'b01);
    tick();
    chk("t6_check2", st_a, 2'b10);
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    chk("t6_done", st_a,  2'b11);
    chk("t6_cyc1", cyc_a, 16'd1);
    chk("t6_pass", pass_a, 1'b1);

    // stop during ARM wins over the arm counter
    start_a = 1'b1; tick(); start_a = 1'b0;
    stop_a = 1'b1; tick(); stop_a = 1'b0;
    chk("arm_stop_state", st_a,   2'b11);
    chk("arm_stop_cyc",   cyc_a,  16'd0);
    chk("arm_stop_pass",  pass_a, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
